alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the operand and result width (legal range 8..64).
REQ-002 SHALL have parameter CTRL_WIDTH, default 4, meaning the opcode width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port ALUctrl, input, CTRL_WIDTH bits: the opcode.
REQ-008 SHALL have ports ALUop1 and ALUop2, input, DATA_WIDTH bits each: the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port SUM, output, DATA_WIDTH bits: the registered result.
REQ-012 SHALL have ports EQ, LT and LTU, output, 1 bit each: registered compares of the accepted operands (equal, signed less-than, unsigned less-than).
REQ-013 SHALL have port busy, output, 1 bit: an iterative operation is in progress.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low half), 11 MULHU, 12 DIVU, 13 REMU; every other opcode gives SUM=0 with flags still computed.
REQ-015 The shift amount SHALL be ALUop2[$clog2(DATA_WIDTH)-1:0]; upper bits are ignored.
REQ-016 All arithmetic SHALL be modulo 2^DATA_WIDTH; SLT and SLTU SHALL return zero-extended 0 or 1.
REQ-017 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the operands and opcode are captured at that edge.
REQ-018 The FSM SHALL have three states: IDLE, CALC and DONE; in_ready=1 only in IDLE.
REQ-019 For single-cycle ops (0-9 and undefined opcodes), acceptance SHALL go IDLE->DONE; out_valid=1 on the next cycle (latency 1).
REQ-020 For ops 10-13, acceptance SHALL go IDLE->CALC; a counter SHALL run DATA_WIDTH cycles of shift-add or restoring-divide; then CALC->DONE; out_valid SHALL assert exactly DATA_WIDTH+1 cycles after acceptance.
REQ-021 busy SHALL be 1 only in CALC.
REQ-022 In DONE, SUM and the flags SHALL hold stable while out_ready=0; DONE->IDLE SHALL occur on the edge where out_ready=1.
REQ-023 There SHALL be no same-cycle result-and-accept: in_ready is 0 in DONE, so a new request is accepted at the earliest one cycle after the result handshake.
REQ-024 DIVU with ALUop2=0 SHALL return all-ones; REMU with ALUop2=0 SHALL return ALUop1; both SHALL still take the full DATA_WIDTH+1 latency.
REQ-025 Changes to ALUctrl, ALUop1 or ALUop2 after acceptance SHALL NOT affect the result in flight.
REQ-026 in_valid while in_ready=0 SHALL be ignored with no side effects.

Reset
REQ-027 rst=1 SHALL, on the next rising edge, force IDLE and set the counter to 0, SUM=0, EQ=LT=LTU=0, out_valid=0 and busy=0; it overrides any handshake on the same edge.
REQ-028 Reset during CALC or DONE SHALL abandon the operation; no out_valid follows for it.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-030 A package alu_pkg SHALL hold the opcode enum (alu_op_t), the state enum (alu_state_t) and the opcode constants; this module and the decoder import it.
REQ-031 The iterative multiply/divide datapath SHALL be one sub-module, mdu_iter (start, op, operands, done, result), driven by the alu_pipe FSM.

Verification
REQ-032 Reset, then ADD 0x7FFFFFFF+1 with out_ready=1 -> out_valid at cycle 1, SUM=0x80000000, LT=0, LTU=0, then in_ready=1.
REQ-033 SRA 0x80000000 by ALUop2=0x24 -> shift amount 4, SUM=0xF8000000; SLT 0xFFFFFFFF vs 1 -> SUM=1; SLTU with the same operands -> SUM=0.
REQ-034 MUL 0xFFFFFFFF*0xFFFFFFFF -> SUM=0x00000001 at cycle 33; MULHU with the same operands -> SUM=0xFFFFFFFE; busy=1 during cycles 1-32.
REQ-035 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; each out_valid at cycle 33.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands -> SUM stable, in_ready=0, no accept; out_ready=1 -> IDLE on the next edge.
REQ-037 Assert rst at cycle 10 of a DIVU -> next cycle IDLE with all outputs zero and no out_valid; a following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the pipelined ALU and its
// iterative multiply/divide unit.
package alu_pkg;

  localparam int unsigned OPC_ADD   = 0;
  localparam int unsigned OPC_SUB   = 1;
  localparam int unsigned OPC_AND   = 2;
  localparam int unsigned OPC_OR    = 3;
  localparam int unsigned OPC_XOR   = 4;
  localparam int unsigned OPC_SLL   = 5;
  localparam int unsigned OPC_SRL   = 6;
  localparam int unsigned OPC_SRA   = 7;
  localparam int unsigned OPC_SLT   = 8;
  localparam int unsigned OPC_SLTU  = 9;
  localparam int unsigned OPC_MUL   = 10;
  localparam int unsigned OPC_MULHU = 11;
  localparam int unsigned OPC_DIVU  = 12;
  localparam int unsigned OPC_REMU  = 13;
  localparam int unsigned NUM_OPS   = 14;

  typedef enum logic [3:0] {
    OP_ADD   = 4'(OPC_ADD),
    OP_SUB   = 4'(OPC_SUB),
    OP_AND   = 4'(OPC_AND),
    OP_OR    = 4'(OPC_OR),
    OP_XOR   = 4'(OPC_XOR),
    OP_SLL   = 4'(OPC_SLL),
    OP_SRL   = 4'(OPC_SRL),
    OP_SRA   = 4'(OPC_SRA),
    OP_SLT   = 4'(OPC_SLT),
    OP_SLTU  = 4'(OPC_SLTU),
    OP_MUL   = 4'(OPC_MUL),
    OP_MULHU = 4'(OPC_MULHU),
    OP_DIVU  = 4'(OPC_DIVU),
    OP_REMU  = 4'(OPC_REMU)
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } alu_state_t;

  function automatic logic is_iter_op(alu_op_t op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_pipe_mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle for DATA_WIDTH cycles after start.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CNTW = $clog2(DATA_WIDTH);

  logic [CNTW-1:0]       cnt;
  logic                  running;
  alu_op_t               mode;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] hi, lo;
  logic [DATA_WIDTH-1:0] hi_n, lo_n;
  logic [DATA_WIDTH:0]   psum;
  logic [DATA_WIDTH:0]   shifted;
  logic                  fits;
  logic                  is_div;

  // hi/lo hold {partial product, multiplier} for MUL or {remainder, quotient}
  // for DIV; both start as {0, a} so the load path is shared.
  always_comb begin
    is_div  = (mode == OP_DIVU) || (mode == OP_REMU);
    psum    = {1'b0, hi} + (lo[0] ? {1'b0, operand_b} : '0);
    shifted = {hi, lo[DATA_WIDTH-1]};
    fits    = shifted >= {1'b0, operand_b};
    if (is_div) begin
      hi_n = fits ? (shifted[DATA_WIDTH-1:0] - operand_b) : shifted[DATA_WIDTH-1:0];
      lo_n = {lo[DATA_WIDTH-2:0], fits};
    end else begin
      hi_n = psum[DATA_WIDTH:1];
      lo_n = {psum[0], lo[DATA_WIDTH-1:1]};
    end
  end

  // The final step's outcome is presented combinationally so the owner can
  // register it on the same edge that completes the iteration.
  always_comb begin
    done   = running && (cnt == CNTW'(DATA_WIDTH - 1));
    result = '0;
    case (mode)
      OP_MUL:   result = lo_n;
      OP_MULHU: result = hi_n;
      OP_DIVU:  result = lo_n;
      OP_REMU:  result = hi_n;
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running   <= 1'b0;
      cnt       <= '0;
      mode      <= OP_MUL;
      operand_b <= '0;
      hi        <= '0;
      lo        <= '0;
    end else if (start) begin
      running   <= 1'b1;
      cnt       <= '0;
      mode      <= op;
      operand_b <= b;
      hi        <= '0;
      lo        <= a;
    end else if (running) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// ALU with valid/ready handshake: single-cycle logic/arith ops and
// iterative multiply/divide, results held until the consumer accepts them.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] SUM,
  output logic                  EQ,
  output logic                  LT,
  output logic                  LTU,
  output logic                  busy
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_t            state, state_n;
  alu_op_t               op;
  logic                  op_defined;
  logic                  iter_op;
  logic                  accept;
  logic [SHW-1:0]        shamt;
  logic                  eq_c, lt_c, ltu_c;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  mdu_done;
  logic [DATA_WIDTH-1:0] mdu_result;

  assign op_defined = ALUctrl < CTRL_WIDTH'(NUM_OPS);
  assign op         = alu_op_t'(ALUctrl[3:0]);
  assign iter_op    = op_defined && is_iter_op(op);
  assign shamt      = ALUop2[SHW-1:0];
  assign eq_c       = ALUop1 == ALUop2;
  assign lt_c       = $signed(ALUop1) < $signed(ALUop2);
  assign ltu_c      = ALUop1 < ALUop2;

  always_comb begin
    alu_res = '0;
    if (op_defined) begin
      case (op)
        OP_ADD:  alu_res = ALUop1 + ALUop2;
        OP_SUB:  alu_res = ALUop1 - ALUop2;
        OP_AND:  alu_res = ALUop1 & ALUop2;
        OP_OR:   alu_res = ALUop1 | ALUop2;
        OP_XOR:  alu_res = ALUop1 ^ ALUop2;
        OP_SLL:  alu_res = ALUop1 << shamt;
        OP_SRL:  alu_res = ALUop1 >> shamt;
        OP_SRA:  alu_res = $unsigned($signed(ALUop1) >>> shamt);
        OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_c};
        OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, ltu_c};
        default: alu_res = '0;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = iter_op ? ST_CALC : ST_DONE;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (mdu_done) state_n = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SUM <= '0;
      EQ  <= 1'b0;
      LT  <= 1'b0;
      LTU <= 1'b0;
    end else if (accept) begin
      EQ  <= eq_c;
      LT  <= lt_c;
      LTU <= ltu_c;
      if (!iter_op) SUM <= alu_res;
    end else if ((state == ST_CALC) && mdu_done) begin
      SUM <= mdu_result;
    end
  end

  mdu_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iter_op),
    .op     (op),
    .a      (ALUop1),
    .b      (ALUop2),
    .done   (mdu_done),
    .result (mdu_result)
  );

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases then randomized ops
// with random output backpressure, checked against a plain arithmetic model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUctrl;
  logic [31:0] ALUop1, ALUop2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SUM;
  logic        EQ, LT, LTU;
  logic        busy;

  typedef struct {
    int          op;
    logic [31:0] sum;
    logic        eq, lt, ltu;
    int          lat;
    int          acc;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_last = 0;
  bit   hold  = 1'b0;
  bit   rand_bp = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;
  logic [31:0] held_sum;
  logic [2:0]  held_flags;

  alu_pipe #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUctrl   (ALUctrl),
    .ALUop1    (ALUop1),
    .ALUop2    (ALUop2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (SUM),
    .EQ        (EQ),
    .LT        (LT),
    .LTU       (LTU),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_sum(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    p  = {32'd0, a} * {32'd0, b};
    sh = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return $unsigned($signed(a) >>> sh);
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic send(input int op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
      return;
    end
    in_valid = 1'b1;
    ALUctrl  = 4'(op);
    ALUop1   = a;
    ALUop2   = b;
    e.op  = op;
    e.sum = ref_sum(op, a, b);
    e.eq  = (a == b);
    e.lt  = ($signed(a) < $signed(b));
    e.ltu = (a < b);
    e.lat = (op >= 10 && op <= 13) ? 33 : 1;
    e.acc = cyc;
    acc_last = cyc;
    expq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUctrl  = 4'($urandom);
    ALUop1   = $urandom;
    ALUop2   = $urandom;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: first cycle of each presented result is scored; later cycles of
  // the same result must hold steady until the handshake.
  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        have_cur   = 1'b1;
        held_sum   = SUM;
        held_flags = {EQ, LT, LTU};
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out_valid: got SUM %0h with nothing outstanding", SUM);
        end else begin
          cur = expq.pop_front();
          check($sformatf("latency op%0d", cur.op), 32'(cyc - cur.acc), 32'(cur.lat));
          check($sformatf("sum op%0d", cur.op), SUM, cur.sum);
          check($sformatf("flags op%0d", cur.op), 32'({EQ, LT, LTU}), 32'({cur.eq, cur.lt, cur.ltu}));
        end
      end else begin
        check("sum_hold", SUM, held_sum);
        check("flags_hold", 32'({EQ, LT, LTU}), 32'(held_flags));
      end
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      if (out_ready) have_cur = 1'b0;
    end
  end

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    ALUctrl  = '0;
    ALUop1   = '0;
    ALUop2   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset SUM", SUM, 32'd0);
    check("reset flags", 32'({EQ, LT, LTU}), 32'd0);

    send(0, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    check("add out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("add in_ready_after", 32'(in_ready), 32'd1);

    send(7, 32'h8000_0000, 32'h24);
    send(8, 32'hFFFF_FFFF, 32'd1);
    send(9, 32'hFFFF_FFFF, 32'd1);
    send(15, 32'd9, 32'd9);

    // Busy window of a multiply; junk requests meanwhile must be ignored.
    send(10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      check($sformatf("mul busy c%0d", k), 32'(busy), (k <= 32) ? 32'd1 : 32'd0);
      in_valid = (k <= 32) ? 1'(k % 2) : 1'b0;
      ALUctrl  = 4'($urandom);
      ALUop1   = $urandom;
      ALUop2   = $urandom;
    end
    send(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(12, 32'd100, 32'd7);
    send(13, 32'd100, 32'd7);
    send(12, 32'd5, 32'd0);
    send(13, 32'd5, 32'd0);

    // Stall a result in DONE while poking the inputs.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    hold = 1'b1;
    @(posedge clk);
    send(4, 32'h1234_5678, 32'h0F0F_0F0F);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'(k % 2 == 0);
      ALUctrl  = 4'($urandom);
      ALUop1   = $urandom;
      ALUop2   = $urandom;
      @(negedge clk);
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    n = 0;
    while (!in_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("release to idle", 32'(in_ready), 32'd1);

    // Reset in the middle of a divide abandons it.
    send(12, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(expq.pop_back());
    @(negedge clk);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort SUM", SUM, 32'd0);
    check("abort flags", 32'({EQ, LT, LTU}), 32'd0);
    send(0, 32'd2, 32'd3);

    rand_bp = 1'b1;
    repeat (150) send($urandom_range(0, 15), pick_operand(), pick_operand());

    n = 0;
    while ((expq.size() != 0 || have_cur) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0 || have_cur) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results still outstanding", expq.size());
    end
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
